random_packet_emitter: RTL and testbench

Parametrised traffic source for NoC simulation. It is the multi-flit, packet-aware successor to the single-flit random emitter. It generates whole packets (head/body/tail flits with routing header) on a 4-phase req/ack channel, with random or fixed destination and length, random or counting payload, and a packet budget. It sits at a router local port in testbenches, one instance per node.

---
 rtl/random_packet_emitter_pkg.sv | 37 +++
 rtl/random_packet_emitter_lfsr32.sv | 35 +++
 rtl/random_packet_emitter.sv | 167 ++++++++++++++++
 tb/tb_random_packet_emitter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/random_packet_emitter_pkg.sv
// rtl/random_packet_emitter_pkg.sv - shared NoC flit definitions for emitters, routers and sinks
//
// Purpose: flit type codes, header field placement derived from the
// destination width DW, LFSR polynomial and emitter FSM state encoding.
package random_packet_emitter_pkg;

  // Flit type lives in the two MSBs of every flit.
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  // Header layout: dest at [DW-1:0], src at [2DW-1:DW], length at [2DW+7:2DW].
  localparam int LEN_W = 8;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RLS  = 2'd2,
    ST_DONE = 2'd3
  } emit_state_e;

  function automatic int dest_width(input int num_nodes);
    return (num_nodes > 1) ? $clog2(num_nodes) : 1;
  endfunction

  function automatic int src_lsb(input int dw);
    return dw;
  endfunction

  function automatic int len_lsb(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/random_packet_emitter_lfsr32.sv
// rtl/random_packet_emitter_lfsr32.sv - 32-bit Galois LFSR, free-running outside reset
//
// Ports:
//   clk      clock
//   reset    asynchronous active-high reset, loads SEED
//   state_o  current 32-bit LFSR state
module lfsr32
  import random_packet_emitter_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Right-shifting Galois form: feed the polynomial back when bit 0 falls out.
  always_comb begin
    state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_POLY : 32'h0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/random_packet_emitter.sv
// rtl/random_packet_emitter.sv - multi-flit random/fixed packet source on a 4-phase req/ack channel
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   en         permits starting new packets (packets in flight always finish)
//   ack        4-phase acknowledge from the router
//   req        4-phase request
//   data       current flit, stable while req is high
//   done       MAX_PACKETS packets have been sent
//   pkt_count  packets completed
//   proto_err  sticky, set when ack is seen high in IDLE or DONE
module random_packet_emitter
  import random_packet_emitter_pkg::*;
#(
  parameter int ID          = 0,
  parameter int SIZE        = 16,
  parameter int NUM_NODES   = 4,
  parameter int PERC_ACTIVE = 100,
  parameter int MAX_PACKETS = 8,
  parameter int PKT_LEN     = 4,
  parameter int LEN_RANDOM  = 0,
  parameter int FIXED_DEST  = -1,
  parameter int COUNT_DATA  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            ack,
  output logic            req,
  output logic [SIZE-1:0] data,
  output logic            done,
  output logic [15:0]     pkt_count,
  output logic            proto_err
);

  localparam int DW = dest_width(NUM_NODES);
  localparam int PW = SIZE - 2;
  localparam logic [DW-1:0] SRC_ID  = ID[DW-1:0];
  localparam logic [DW-1:0] NEXT_ID = DW'((ID + 1) % NUM_NODES);

  emit_state_e       state_q, state_d;
  logic              req_q, req_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic [15:0]       pkt_q, pkt_d;
  logic              perr_q, perr_d;
  logic [PW-1:0]     seq_q, seq_d;
  logic [LEN_W-1:0]  left_q, left_d;

  logic [31:0]       lfsr_w;
  logic [31:0]       rnd_dest;
  logic [DW-1:0]     dest_new;
  logic [LEN_W-1:0]  len_new;
  logic [PW-1:0]     payload;
  logic              roll_ok;
  logic              budget_hit;
  logic              budget_next;

  lfsr32 #(.SEED(32'(ID + 1))) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .state_o (lfsr_w)
  );

  function automatic logic [SIZE-1:0] head_flit(input logic [1:0] ft,
                                                 input logic [DW-1:0] dst,
                                                 input logic [LEN_W-1:0] ln);
    logic [SIZE-1:0] f;
    f = '0;
    f[SIZE-1 -: 2]           = ft;
    f[DW-1:0]                = dst;
    f[src_lsb(DW) +: DW]     = SRC_ID;
    f[len_lsb(DW) +: LEN_W]  = ln;
    return f;
  endfunction

  always_comb begin
    rnd_dest = lfsr_w % 32'(NUM_NODES);
    if (FIXED_DEST >= 0) begin
      dest_new = DW'(FIXED_DEST);
    end else if (NUM_NODES == 1) begin
      dest_new = '0;
    end else if (rnd_dest == ID) begin
      // Never address ourselves; bump to the next node.
      dest_new = NEXT_ID;
    end else begin
      dest_new = DW'(rnd_dest);
    end
    len_new     = (LEN_RANDOM != 0) ? LEN_W'(32'd1 + (lfsr_w % 32'(PKT_LEN))) : LEN_W'(PKT_LEN);
    payload     = (COUNT_DATA != 0) ? seq_q : PW'(lfsr_w);
    roll_ok     = (lfsr_w % 32'd100) < PERC_ACTIVE;
    budget_hit  = {16'd0, pkt_q} >= MAX_PACKETS;
    budget_next = ({16'd0, pkt_q} + 32'd1) >= MAX_PACKETS;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    pkt_d   = pkt_q;
    seq_d   = seq_q;
    left_d  = left_q;
    perr_d  = perr_q | (ack && (state_q == ST_IDLE || state_q == ST_DONE));
    case (state_q)
      ST_IDLE: begin
        if (budget_hit) begin
          state_d = ST_DONE;
        end else if (en && !ack && roll_ok) begin
          req_d   = 1'b1;
          left_d  = len_new - LEN_W'(1);
          data_d  = head_flit((len_new == LEN_W'(1)) ? FT_SINGLE : FT_HEAD, dest_new, len_new);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = ST_RLS;
        end
      end
      ST_RLS: begin
        if (!ack) begin
          if (left_q != '0) begin
            // Remaining flits go out back to back, independent of en and roll.
            req_d   = 1'b1;
            left_d  = left_q - LEN_W'(1);
            seq_d   = seq_q + PW'(1);
            data_d  = {((left_q == LEN_W'(1)) ? FT_TAIL : FT_BODY), payload};
            state_d = ST_REQ;
          end else begin
            pkt_d   = pkt_q + 16'd1;
            state_d = budget_next ? ST_DONE : ST_IDLE;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      pkt_q   <= '0;
      perr_q  <= 1'b0;
      seq_q   <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      pkt_q   <= pkt_d;
      perr_q  <= perr_d;
      seq_q   <= seq_d;
      left_q  <= left_d;
    end
  end

  assign req       = req_q;
  assign data      = data_q;
  assign done      = (state_q == ST_DONE);
  assign pkt_count = pkt_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_random_packet_emitter.sv
// tb/tb_random_packet_emitter.sv - directed self-checking bench for random_packet_emitter
module tb_random_packet_emitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: ID=1, PKT_LEN=3, MAX_PACKETS=2, fixed dest 3, counting payload
  logic        rst_a, en_a, auto_a, man_a, resp_a, ack_a;
  logic        req_a, done_a, perr_a;
  logic [15:0] data_a, cnt_a;
  assign ack_a = auto_a ? resp_a : man_a;
  always @(posedge clk) resp_a <= req_a;

  random_packet_emitter #(.ID(1), .SIZE(16), .NUM_NODES(4), .PERC_ACTIVE(100), .MAX_PACKETS(2),
                          .PKT_LEN(3), .LEN_RANDOM(0), .FIXED_DEST(3), .COUNT_DATA(1)) u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .ack(ack_a), .req(req_a), .data(data_a),
    .done(done_a), .pkt_count(cnt_a), .proto_err(perr_a));

  // Instance B: single-flit packets, MAX_PACKETS=3
  logic        resp_b, req_b, done_b, perr_b;
  logic [15:0] data_b, cnt_b;
  always @(posedge clk) resp_b <= req_b;

  random_packet_emitter #(.ID(1), .SIZE(16), .NUM_NODES(4), .PERC_ACTIVE(100), .MAX_PACKETS(3),
                          .PKT_LEN(1), .LEN_RANDOM(0), .FIXED_DEST(3), .COUNT_DATA(1)) u_b (
    .clk(clk), .reset(rst_a), .en(en_a), .ack(resp_b), .req(req_b), .data(data_b),
    .done(done_b), .pkt_count(cnt_b), .proto_err(perr_b));

  // Instance R: random destination and length
  logic        rst_r, en_r, resp_r, req_r, done_r, perr_r;
  logic [15:0] data_r, cnt_r;
  always @(posedge clk) resp_r <= req_r;

  random_packet_emitter #(.ID(2), .SIZE(16), .NUM_NODES(4), .PERC_ACTIVE(30), .MAX_PACKETS(200),
                          .PKT_LEN(5), .LEN_RANDOM(1), .FIXED_DEST(-1), .COUNT_DATA(1)) u_r (
    .clk(clk), .reset(rst_r), .en(en_r), .ack(resp_r), .req(req_r), .data(data_r),
    .done(done_r), .pkt_count(cnt_r), .proto_err(perr_r));

  // Flit monitors: record each rising req with its cycle stamp
  logic [15:0] fa[$];
  int          ca[$];
  logic        prev_a = 1'b0;
  always @(negedge clk) begin
    if (req_a && !prev_a) begin
      fa.push_back(data_a);
      ca.push_back(cyc);
    end
    prev_a <= req_a;
  end

  logic [15:0] fb[$];
  int          cb[$];
  int          cdb[$];
  logic        prev_b = 1'b0;
  logic [15:0] pcnt_b = '0;
  always @(negedge clk) begin
    if (req_b && !prev_b) begin
      fb.push_back(data_b);
      cb.push_back(cyc);
    end
    if (cnt_b != pcnt_b) cdb.push_back(cyc);
    prev_b <= req_b;
    pcnt_b <= cnt_b;
  end

  logic [15:0] tr[$];
  logic        prev_r = 1'b0;
  int          flits_r = 0, heads_r = 0, sumlen_r = 0, bad_r = 0;
  always @(negedge clk) begin
    if (req_r && !prev_r) begin
      tr.push_back(data_r);
      flits_r <= flits_r + 1;
      if (data_r[15:14] == 2'b01 || data_r[15:14] == 2'b11) begin
        heads_r  <= heads_r + 1;
        sumlen_r <= sumlen_r + int'(data_r[11:4]);
        if (data_r[1:0] == 2'd2 || data_r[3:2] != 2'd2 || data_r[13:12] != 2'd0 ||
            data_r[11:4] < 8'd1 || data_r[11:4] > 8'd5 ||
            ((data_r[11:4] == 8'd1) != (data_r[15:14] == 2'b11)))
          bad_r <= bad_r + 1;
      end
    end
    prev_r <= req_r;
  end

  logic [15:0] exp1 [6] = '{16'h4037, 16'h0000, 16'h8001, 16'h4037, 16'h0002, 16'h8003};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int t0, b2, b3, b4, b5, b6, n1, mism;
  int h0, f0, s0, x0;

  initial begin
    rst_a = 1'b1; en_a = 1'b0; auto_a = 1'b1; man_a = 1'b0;
    rst_r = 1'b1; en_r = 1'b0;
    repeat (3) step();

    chk("rst_req",  32'(req_a),  32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_cnt",  32'(cnt_a),  32'd0);
    chk("rst_perr", 32'(perr_a), 32'd0);

    // Two 3-flit packets then done; singles on instance B
    en_a = 1'b1; t0 = cyc; rst_a = 1'b0;
    for (int n = 0; n < 300 && !(done_a && done_b); n++) step();
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_cnt",  32'(cnt_a),  32'd2);
    chk("t1_nflit", fa.size(), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t1_flit%0d", i), 32'(fa[i]), 32'(exp1[i]));
    chk("t1_latency", ca[0], t0 + 1);
    chk("t1_period",  ca[1] - ca[0], 32'd4);
    repeat (10) step();
    chk("t1_req_idle", 32'(req_a), 32'd0);
    chk("t1_no_more",  fa.size(), 32'd6);
    chk("t1_perr",     32'(perr_a), 32'd0);
    chk("sg_done",  32'(done_b), 32'd1);
    chk("sg_cnt",   32'(cnt_b),  32'd3);
    chk("sg_nflit", fb.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sg_flit%0d", i), 32'(fb[i]), 32'hC017);
      chk($sformatf("sg_period%0d", i), cdb[i] - cb[i], 32'd4);
    end

    // en dropped during the body flit of packet 1
    rst_a = 1'b1; step(); step(); b2 = fa.size(); rst_a = 1'b0;
    for (int n = 0; n < 100 && fa.size() < b2 + 2; n++) step();
    en_a = 1'b0;
    for (int n = 0; n < 100 && cnt_a != 16'd1; n++) step();
    repeat (20) step();
    chk("en_cnt",   32'(cnt_a), 32'd1);
    chk("en_nflit", fa.size() - b2, 32'd3);
    chk("en_tail",  32'(fa[b2 + 2]), 32'h8001);
    chk("en_req",   32'(req_a), 32'd0);
    en_a = 1'b1;
    for (int n = 0; n < 200 && !done_a; n++) step();
    chk("en_head2", 32'(fa[b2 + 3]), 32'h4037);
    chk("en_cnt2",  32'(cnt_a), 32'd2);

    // Reset while the body flit is being requested
    rst_a = 1'b1; step(); step(); b3 = fa.size(); rst_a = 1'b0;
    for (int n = 0; n < 100 && fa.size() < b3 + 2; n++) step();
    chk("rs_body_req", 32'(req_a), 32'd1);
    #2 rst_a = 1'b1;
    #1;
    chk("rs_async_req", 32'(req_a), 32'd0);
    chk("rs_cnt",       32'(cnt_a), 32'd0);
    step(); step(); b4 = fa.size(); rst_a = 1'b0;
    for (int n = 0; n < 200 && !done_a; n++) step();
    chk("rs_head", 32'(fa[b4]),     32'h4037);
    chk("rs_body", 32'(fa[b4 + 1]), 32'h0000);
    chk("rs_tail", 32'(fa[b4 + 2]), 32'h8001);

    // ack high while IDLE
    auto_a = 1'b0; man_a = 1'b1; rst_a = 1'b1; step(); step(); rst_a = 1'b0;
    step(); step();
    chk("pe_set",   32'(perr_a), 32'd1);
    chk("pe_block", 32'(req_a),  32'd0);
    man_a = 1'b0; step();
    chk("pe_start",  32'(req_a),  32'd1);
    chk("pe_head",   32'(data_a), 32'h4037);
    chk("pe_sticky", 32'(perr_a), 32'd1);
    auto_a = 1'b1;

    // Random mode, 200 packets, then a repeat run for determinism
    b5 = tr.size(); h0 = heads_r; f0 = flits_r; s0 = sumlen_r; x0 = bad_r;
    en_r = 1'b1; rst_r = 1'b0;
    for (int n = 0; n < 30000 && !done_r; n++) step();
    step();
    chk("rn_done",  32'(done_r), 32'd1);
    chk("rn_cnt",   32'(cnt_r),  32'd200);
    chk("rn_heads", heads_r - h0, 32'd200);
    chk("rn_flits", flits_r - f0, sumlen_r - s0);
    chk("rn_bad",   bad_r - x0, 32'd0);
    chk("rn_perr",  32'(perr_r), 32'd0);
    rst_r = 1'b1; step(); step(); b6 = tr.size(); rst_r = 1'b0;
    for (int n = 0; n < 30000 && !done_r; n++) step();
    step();
    n1 = b6 - b5;
    chk("rn_rep_len", tr.size() - b6, n1);
    mism = 0;
    for (int i = 0; i < n1 && b6 + i < tr.size(); i++)
      if (tr[b5 + i] !== tr[b6 + i]) mism++;
    chk("rn_rep_trace", mism, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
